// File: rtl/acel_tilt_decoder.sv
// rtl/acel_tilt_decoder.sv - accelerometer tilt decoder with hysteresis, persistence and loss-of-signal timeout
// Build option: define ACEL_PROMEDIO_EN to filter through a 4-sample moving average window.
module acel_tilt_decoder #(
    parameter int UMBRAL_ON      = 40,
    parameter int UMBRAL_OFF     = 20,
    parameter int PERSISTENCIA   = 3,
    parameter int TIMEOUT_CICLOS = 5_000_000
) (
    input  logic       iClk,
    input  logic       iReset,
    input  logic [7:0] iDato,
    input  logic       iDatoValido,
    output logic       oDerecha,
    output logic       oIzquierda,
    output logic       oSinSenal,
    output logic [7:0] oFiltrado
);
    typedef enum logic [1:0] {
        CENTRO    = 2'd0,
        DERECHA   = 2'd1,
        IZQUIERDA = 2'd2
    } tEstado;

    localparam logic [23:0] TIMEOUT_MAX = 24'(TIMEOUT_CICLOS);

    tEstado             estado;
    tEstado             estadoSig;
    tEstado             destino;
    logic [3:0]         cuentaPers;
    logic [3:0]         cuentaSig;
    logic [3:0]         racha;
    logic               dirPend;
    logic               dirSig;
    logic               cumple;
    logic               haciaIzq;
    logic [23:0]        cuentaTimeout;
    logic               timeoutEvento;
    logic               muestraValida;
    logic               filtradoValido;
    logic [7:0]         filtNuevo;
    logic signed [31:0] filtExt;

    // A strobe on the would-be timeout edge wins, so the event needs an idle input.
    assign timeoutEvento = !iDatoValido && (cuentaTimeout != TIMEOUT_MAX)
                           && (cuentaTimeout + 24'd1 == TIMEOUT_MAX);

`ifdef ACEL_PROMEDIO_EN
    logic [7:0] ventana [4];
    logic [9:0] suma;

    assign suma = {{2{ventana[0][7]}}, ventana[0]} + {{2{ventana[1][7]}}, ventana[1]}
                + {{2{ventana[2][7]}}, ventana[2]} + {{2{ventana[3][7]}}, ventana[3]};
    // Dropping the two LSBs of the signed sum is the arithmetic shift right by 2.
    assign filtNuevo = suma[9:2];

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            for (int i = 0; i < 4; i++) ventana[i] <= '0;
        end else if (iDatoValido) begin
            ventana[0] <= iDato;
            ventana[1] <= ventana[0];
            ventana[2] <= ventana[1];
            ventana[3] <= ventana[2];
        end else if (timeoutEvento) begin
            for (int i = 0; i < 4; i++) ventana[i] <= '0;
        end
    end
`else
    logic [7:0] ultimo;

    assign filtNuevo = ultimo;

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            ultimo <= '0;
        end else if (iDatoValido) begin
            ultimo <= iDato;
        end else if (timeoutEvento) begin
            ultimo <= '0;
        end
    end
`endif

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            muestraValida  <= 1'b0;
            filtradoValido <= 1'b0;
            cuentaTimeout  <= '0;
            oSinSenal      <= 1'b0;
            oFiltrado      <= '0;
        end else begin
            muestraValida  <= iDatoValido;
            filtradoValido <= muestraValida && !timeoutEvento;
            if (iDatoValido) begin
                cuentaTimeout <= '0;
                oSinSenal     <= 1'b0;
            end else if (timeoutEvento) begin
                cuentaTimeout <= TIMEOUT_MAX;
                oSinSenal     <= 1'b1;
            end else if (cuentaTimeout != TIMEOUT_MAX) begin
                cuentaTimeout <= cuentaTimeout + 24'd1;
            end
            if (timeoutEvento) begin
                oFiltrado <= '0;
            end else if (muestraValida) begin
                oFiltrado <= filtNuevo;
            end
        end
    end

    assign filtExt = {{24{oFiltrado[7]}}, oFiltrado};

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            estado     <= CENTRO;
            cuentaPers <= '0;
            dirPend    <= 1'b0;
            oDerecha   <= 1'b0;
            oIzquierda <= 1'b0;
        end else begin
            estado     <= estadoSig;
            cuentaPers <= cuentaSig;
            dirPend    <= dirSig;
            oDerecha   <= (estadoSig == DERECHA);
            oIzquierda <= (estadoSig == IZQUIERDA);
        end
    end

    always_comb begin
        estadoSig = estado;
        cuentaSig = cuentaPers;
        dirSig    = dirPend;
        cumple    = 1'b0;
        haciaIzq  = 1'b0;
        destino   = CENTRO;
        racha     = '0;
        if (timeoutEvento) begin
            estadoSig = CENTRO;
            cuentaSig = '0;
            dirSig    = 1'b0;
        end else if (filtradoValido) begin
            case (estado)
                CENTRO: begin
                    if (filtExt >= UMBRAL_ON) begin
                        cumple  = 1'b1;
                        destino = DERECHA;
                    end else if (filtExt <= -UMBRAL_ON) begin
                        cumple   = 1'b1;
                        haciaIzq = 1'b1;
                        destino  = IZQUIERDA;
                    end
                end
                // Lateral states only ever exit to CENTRO, whatever the tilt direction.
                DERECHA:   cumple = (filtExt < UMBRAL_OFF);
                IZQUIERDA: cumple = (filtExt > -UMBRAL_OFF);
                default:   estadoSig = CENTRO;
            endcase
            if (!cumple) begin
                cuentaSig = '0;
                dirSig    = 1'b0;
            end else begin
                // A run toward the opposite side in CENTRO starts over from one.
                racha = (dirPend == haciaIzq) ? cuentaPers : 4'd0;
                if (int'(racha) + 1 >= PERSISTENCIA) begin
                    estadoSig = destino;
                    cuentaSig = '0;
                    dirSig    = 1'b0;
                end else begin
                    cuentaSig = racha + 4'd1;
                    dirSig    = haciaIzq;
                end
            end
        end
    end
endmodule

// File: tb/tb_acel_tilt_decoder.sv
// tb/tb_acel_tilt_decoder.sv - scoreboard bench for acel_tilt_decoder against a behavioural model
module tb_acel_tilt_decoder;
    localparam int ON  = 40;
    localparam int OFF = 20;
    localparam int P   = 3;
    localparam int T   = 100;

    logic       iClk = 1'b0;
    logic       iReset;
    logic [7:0] iDato;
    logic       iDatoValido;
    logic       oDerecha;
    logic       oIzquierda;
    logic       oSinSenal;
    logic [7:0] oFiltrado;

    always #5 iClk = ~iClk;

    acel_tilt_decoder #(
        .UMBRAL_ON(ON),
        .UMBRAL_OFF(OFF),
        .PERSISTENCIA(P),
        .TIMEOUT_CICLOS(T)
    ) dut (
        .iClk(iClk),
        .iReset(iReset),
        .iDato(iDato),
        .iDatoValido(iDatoValido),
        .oDerecha(oDerecha),
        .oIzquierda(oIzquierda),
        .oSinSenal(oSinSenal),
        .oFiltrado(oFiltrado)
    );

    typedef struct {
        int cyc;
        int val;
    } tEvento;

    typedef struct {
        int   cyc;
        logic der;
        logic izq;
        logic sin;
        int   filt;
    } tEsperado;

    tEsperado expQ[$];
    int       nChecks = 0;
    int       nPass   = 0;

    // Model state: 0 centre, 1 right, 2 left
    int     mState;
    int     mFilt;
    int     mSin;
    int     mIdle;
    int     cyc = 0;
    int     win[$];
    int     hist[$];
    tEvento filtQ[$];
    tEvento evalQ[$];
    int     bases[7] = '{-120, -60, -30, 0, 30, 60, 120};

    function automatic int promedio();
        int s = 0;
`ifdef ACEL_PROMEDIO_EN
        foreach (win[i]) s += win[i];
        if (s >= 0) return s / 4;
        return -((-s + 3) / 4);
`else
        s = win[win.size() - 1];
        return s;
`endif
    endfunction

    task automatic modelReset();
        mState = 0;
        mFilt  = 0;
        mSin   = 0;
        mIdle  = 0;
        win    = '{0, 0, 0, 0};
        hist.delete();
        filtQ.delete();
        evalQ.delete();
    endtask

    // Class of a filtered sample: 1 toward right, 2 toward left, 3 toward centre, 0 none
    task automatic evaluar(input int f);
        int  c;
        bit  todos;
        if (mState == 0)      c = (f >= ON) ? 1 : ((f <= -ON) ? 2 : 0);
        else if (mState == 1) c = (f < OFF) ? 3 : 0;
        else                  c = (f > -OFF) ? 3 : 0;
        hist.push_back(c);
        if (c != 0 && hist.size() >= P) begin
            todos = 1'b1;
            for (int k = hist.size() - P; k < hist.size(); k++)
                if (hist[k] != c) todos = 1'b0;
            if (todos) begin
                mState = (c == 3) ? 0 : c;
                hist.delete();
            end
        end
    endtask

    task automatic modelStep(input logic v, input int d, input logic r);
        int     prevIdle;
        bit     to;
        tEvento e;
        if (r) begin
            modelReset();
        end else begin
            prevIdle = mIdle;
            if (v) mIdle = 0;
            else if (mIdle < T) mIdle++;
            to = !v && (prevIdle == T - 1);
            if (evalQ.size() > 0 && evalQ[0].cyc == cyc) begin
                e = evalQ.pop_front();
                if (!to) evaluar(e.val);
            end
            if (filtQ.size() > 0 && filtQ[0].cyc == cyc) begin
                e = filtQ.pop_front();
                if (!to) begin
                    mFilt = e.val;
                    evalQ.push_back(tEvento'{cyc + 1, e.val});
                end
            end
            if (v) begin
                void'(win.pop_front());
                win.push_back(d);
                filtQ.push_back(tEvento'{cyc + 1, promedio()});
                mSin = 0;
            end
            if (to) begin
                mState = 0;
                mFilt  = 0;
                mSin   = 1;
                win    = '{0, 0, 0, 0};
                hist.delete();
                filtQ.delete();
                evalQ.delete();
            end
        end
        expQ.push_back(tEsperado'{cyc, mState == 1, mState == 2, mSin != 0, mFilt});
        cyc++;
    endtask

    task automatic ciclo(input logic v, input int d, input logic r);
        @(negedge iClk);
        iDatoValido = v;
        iDato       = 8'(d);
        if (r && !iReset) begin
            iReset = 1'b1;
            #1;
            nChecks++;
            if (oDerecha === 1'b0 && oIzquierda === 1'b0 && oSinSenal === 1'b0 && oFiltrado === 8'h00)
                nPass++;
            else
                $display("FAIL reset_inmediato: got der=%0b izq=%0b sin=%0b filt=%0d, expected all 0",
                         oDerecha, oIzquierda, oSinSenal, $signed(oFiltrado));
        end else begin
            iReset = r;
        end
        modelStep(v, d, r);
    endtask

    task automatic ocioso(input int n);
        repeat (n) ciclo(1'b0, int'($urandom_range(0, 255)), 1'b0);
    endtask

    task automatic muestra(input int val, input int gap);
        ciclo(1'b1, val, 1'b0);
        ocioso(gap);
    endtask

    initial begin : monitor
        tEsperado e;
        int       act;
        forever begin
            @(posedge iClk);
            #2;
            if (expQ.size() > 0) begin
                e   = expQ.pop_front();
                act = int'($signed(oFiltrado));
                nChecks++;
                if (oDerecha === e.der && oIzquierda === e.izq && oSinSenal === e.sin && act == e.filt)
                    nPass++;
                else
                    $display("FAIL salida cyc=%0d: got der=%0b izq=%0b sin=%0b filt=%0d, expected der=%0b izq=%0b sin=%0b filt=%0d",
                             e.cyc, oDerecha, oIzquierda, oSinSenal, act, e.der, e.izq, e.sin, e.filt);
            end
        end
    end

    initial begin : driver
        int base;
        int len;
        int val;
        int sel;
        iReset      = 1'b1;
        iDatoValido = 1'b0;
        iDato       = 8'h00;
        modelReset();
        ciclo(1'b0, 0, 1'b1);
        ciclo(1'b0, 0, 1'b1);
        ocioso(2);

        repeat (6) muestra(80, int'($urandom_range(0, 2)));
        ocioso(3);
        repeat (8) muestra(-100, int'($urandom_range(0, 2)));
        ocioso(3);
        repeat (8) muestra(80, int'($urandom_range(0, 2)));
        repeat (5) begin
            muestra(30, int'($urandom_range(0, 2)));
            muestra(10, int'($urandom_range(0, 2)));
        end
        repeat (6) muestra(80, 1);

        ocioso(T + 5);
        repeat (6) muestra(80, int'($urandom_range(0, 2)));
        muestra(80, 0);
        ocioso(T - 1);
        muestra(80, 0);
        ocioso(T);
        repeat (6) muestra(80, 0);

        muestra(127, 0);
        ciclo(1'b0, 0, 1'b1);
        ciclo(1'b0, 0, 1'b1);
        ocioso(1);
        muestra(40, 3);

        for (int b = 0; b < 60; b++) begin
            base = bases[$urandom_range(0, 6)];
            len  = int'($urandom_range(3, 12));
            for (int k = 0; k < len; k++) begin
                val = base + int'($urandom_range(0, 40)) - 20;
                if (val > 127) val = 127;
                if (val < -128) val = -128;
                muestra(val, int'($urandom_range(0, 2)));
            end
            sel = int'($urandom_range(0, 19));
            if (sel == 0) ocioso(int'($urandom_range(T - 2, T + 2)));
            else if (sel == 1) begin
                ciclo(1'b0, 0, 1'b1);
                ciclo(1'b0, 0, 1'b1);
            end
        end

        @(negedge iClk);
        iDatoValido = 1'b0;
        for (int k = 0; k < 10 && expQ.size() > 0; k++) @(posedge iClk);
        #3;
        if (expQ.size() > 0) begin
            nChecks++;
            $display("FAIL drenaje: got %0d pending expectations, expected 0", expQ.size());
        end
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
